sweep_limit_fsm: RTL and testbench
==================================

SWEEP_LIMIT_FSM -- requirements
Module: sweep_limit_fsm

Interface
REQ-001 Parameter CNT_W, default 5: width of the guard and debounce counters.
REQ-002 Parameter GUARD, default 31: cycles spent sweeping before the limit input is honoured; legal range 1..2**CNT_W-1.
REQ-003 Parameter DEB, default 4: consecutive high samples of the active limit required to accept it; legal range 1..2**CNT_W-1.
REQ-004 Parameter BIDIR, default 0: 0 = single sweep toward LIM_HI; 1 = sweep toward LIM_HI, reverse, then sweep toward LIM_LO.
REQ-005 CLK  input  1  system clock; all state changes on rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 EN  input  1  sweep enable from the tracker controller; level-sensitive.
REQ-008 LIM_HI  input  1  servo at high end of travel (180 degrees); may glitch.
REQ-009 LIM_LO  input  1  servo at low end of travel (0 degrees); may glitch.
REQ-010 CNT_L  output  1  registered; high while the servo shall keep sweeping.
REQ-011 DIR  output  1  registered; 0 = toward LIM_HI, 1 = toward LIM_LO.
REQ-012 DONE  output  1  registered; one-cycle pulse when the sweep completes.
REQ-013 STATE  output  2  registered FSM state for debug: 00 IDLE, 01 GUARD, 10 SEEK, 11 FIN.

Function
REQ-014 The FSM SHALL have exactly four states, IDLE, GUARD, SEEK and FIN, with the encodings given in REQ-013.
REQ-015 In any state, EN sampled low SHALL move the FSM to IDLE on that edge: CNT_L=0, DIR=0, DONE=0, both counters cleared.
REQ-016 IDLE with EN high SHALL move the FSM to GUARD on that edge: CNT_L=1, DIR=0, guard counter=0.
REQ-017 The FSM SHALL remain in GUARD for exactly GUARD cycles, with the guard counter incrementing each cycle, then enter SEEK; LIM_HI and LIM_LO are ignored in GUARD and the debounce counter is held at 0.
REQ-018 In SEEK, the active limit SHALL be LIM_HI when DIR=0 and LIM_LO when DIR=1; the inactive limit is ignored, including when both limits are high.
REQ-019 In SEEK, the debounce counter SHALL increment on each edge where the active limit is high and clear to 0 on any edge where it is low.
REQ-020 On the DEB-th consecutive high sample of the active limit in SEEK: if BIDIR=1 and DIR=0, DIR SHALL become 1 and the FSM SHALL re-enter GUARD with both counters cleared and CNT_L held high; otherwise the FSM SHALL enter FIN.
REQ-021 On entry to FIN, CNT_L SHALL go to 0 and DONE SHALL be 1 for exactly that one cycle; DIR SHALL retain its value.
REQ-022 FIN SHALL persist while EN is high, with no further DONE pulse; EN low SHALL return the FSM to IDLE per REQ-015.
REQ-023 With the active limit held high, CNT_L SHALL stay high for exactly GUARD+DEB cycles for BIDIR=0, and 2*(GUARD+DEB) cycles for BIDIR=1.
REQ-024 The counters SHALL never wrap; each is bounded by its terminal value (GUARD-1 or DEB-1).
REQ-025 The module SHALL contain no combinational path from any input to any output.

Reset
REQ-026 RST_N low SHALL, asynchronously and regardless of CLK, force IDLE, CNT_L=0, DIR=0, DONE=0, STATE=00, and clear both counters.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no DONE pulse.
REQ-028 After RST_N deasserts, the first EN-high edge SHALL start a sweep per REQ-016.

Verification
REQ-029 Defaults, EN=1, LIM_HI=1 throughout -> CNT_L high for exactly 35 cycles, then DONE is a single 1-cycle pulse, STATE=11.
REQ-030 Defaults; in SEEK, LIM_HI pattern 1,1,1,0,1,1,1,1 -> debounce clears on the 0; CNT_L falls on the 8th sample edge.
REQ-031 BIDIR=1, GUARD=3, DEB=2; LIM_HI high in first SEEK, LIM_LO high in second -> DIR 0->1 after 5 cycles, CNT_L unbroken for 10 cycles, then DONE pulses once.
REQ-032 Defaults; LIM_LO=1 and LIM_HI=0 during SEEK -> CNT_L remains high indefinitely and DONE never asserts.
REQ-033 Defaults; EN dropped at cycle 10 of GUARD and reasserted two cycles later -> IDLE is reached and a fresh 31-cycle guard restarts.
REQ-034 RST_N pulsed low between clock edges during SEEK -> outputs reach their REQ-026 values immediately and no DONE pulse occurs.

Source files
------------

// File: rtl/sweep_limit_fsm.sv
// Servo sweep controller: sweeps until a debounced end-of-travel limit is seen,
// optionally reversing once to sweep back toward the low limit before finishing.
module sweep_limit_fsm #(
    parameter int CNT_W = 5,
    parameter int GUARD = 31,
    parameter int DEB   = 4,
    parameter bit BIDIR = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       LIM_HI,
    input  logic       LIM_LO,
    output logic       CNT_L,
    output logic       DIR,
    output logic       DONE,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GUARD = 2'b01,
        S_SEEK  = 2'b10,
        S_FIN   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB - 1);

    state_t           state;
    logic [CNT_W-1:0] guard_cnt;
    logic [CNT_W-1:0] deb_cnt;
    logic             lim_act;

    // The limit being approached; the opposite end is never consulted.
    assign lim_act = DIR ? LIM_LO : LIM_HI;
    assign STATE   = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            CNT_L     <= 1'b0;
            DIR       <= 1'b0;
            DONE      <= 1'b0;
            guard_cnt <= '0;
            deb_cnt   <= '0;
        end else if (!EN) begin
            state     <= S_IDLE;
            CNT_L     <= 1'b0;
            DIR       <= 1'b0;
            DONE      <= 1'b0;
            guard_cnt <= '0;
            deb_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_GUARD;
                    CNT_L     <= 1'b1;
                    DIR       <= 1'b0;
                    DONE      <= 1'b0;
                    guard_cnt <= '0;
                    deb_cnt   <= '0;
                end
                S_GUARD: begin
                    // Limits are blind here so the servo can leave the stop it starts on.
                    deb_cnt <= '0;
                    if (guard_cnt == GUARD_LAST) begin
                        state     <= S_SEEK;
                        guard_cnt <= '0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                S_SEEK: begin
                    if (!lim_act) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt != DEB_LAST) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end else if (BIDIR && !DIR) begin
                        DIR       <= 1'b1;
                        state     <= S_GUARD;
                        guard_cnt <= '0;
                        deb_cnt   <= '0;
                    end else begin
                        state   <= S_FIN;
                        CNT_L   <= 1'b0;
                        DONE    <= 1'b1;
                        deb_cnt <= '0;
                    end
                end
                S_FIN: begin
                    DONE <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    CNT_L <= 1'b0;
                    DIR   <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_limit_fsm.sv
// Directed bench for sweep_limit_fsm: default single sweep plus a short bidirectional instance.
module tb_sweep_limit_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, lim_hi, lim_lo, cnt_l, dir, done;
    logic [1:0] state;
    logic       b_en, b_lim_hi, b_lim_lo, b_cnt_l, b_dir, b_done;
    logic [1:0] b_state;

    int n_checks = 0;
    int n_fail   = 0;

    sweep_limit_fsm dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .LIM_HI(lim_hi), .LIM_LO(lim_lo),
        .CNT_L(cnt_l), .DIR(dir), .DONE(done), .STATE(state)
    );

    sweep_limit_fsm #(.CNT_W(5), .GUARD(3), .DEB(2), .BIDIR(1'b1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .EN(b_en), .LIM_HI(b_lim_hi), .LIM_LO(b_lim_lo),
        .CNT_L(b_cnt_l), .DIR(b_dir), .DONE(b_done), .STATE(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; lim_hi = 1'b0; lim_lo = 1'b0;
        b_en = 1'b0; b_lim_hi = 1'b0; b_lim_lo = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
        n_checks++; if (cnt_l !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_l: got %b expected 0", cnt_l); end
        n_checks++; if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b expected 0", dir); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (b_state !== 2'b00) begin n_fail++; $display("FAIL reset_b_state: got %b expected 00", b_state); end
        en = 1'b1;
        tick(); tick();
        n_checks++; if (state !== 2'b00 || cnt_l !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got state %b cnt_l %b expected 00/0", state, cnt_l); end
        en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_en_low: got %b expected 00", state); end
    endtask

    task automatic test_single_sweep();
        logic [1:0] exp_st;
        en = 1'b1; lim_hi = 1'b1; lim_lo = 1'b0;
        for (int e = 0; e < 35; e++) begin
            tick();
            exp_st = (e <= 30) ? 2'b01 : 2'b10;
            n_checks++; if (cnt_l !== 1'b1) begin n_fail++; $display("FAIL sweep_cnt_l e=%0d: got %b expected 1", e, cnt_l); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL sweep_done e=%0d: got %b expected 0", e, done); end
            n_checks++; if (state !== exp_st) begin n_fail++; $display("FAIL sweep_state e=%0d: got %b expected %b", e, state, exp_st); end
        end
        tick();
        n_checks++; if (cnt_l !== 1'b0) begin n_fail++; $display("FAIL fin_cnt_l: got %b expected 0", cnt_l); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fin_done_pulse: got %b expected 1", done); end
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("FAIL fin_state: got %b expected 11", state); end
        n_checks++; if (dir !== 1'b0) begin n_fail++; $display("FAIL fin_dir: got %b expected 0", dir); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (done !== 1'b0 || state !== 2'b11) begin n_fail++; $display("FAIL fin_hold k=%0d: got done %b state %b expected 0/11", k, done, state); end
        end
        en = 1'b0; lim_hi = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00 || cnt_l !== 1'b0) begin n_fail++; $display("FAIL fin_to_idle: got state %b cnt_l %b expected 00/0", state, cnt_l); end
    endtask

    task automatic test_debounce();
        logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_end;
        en = 1'b1; lim_hi = 1'b0; lim_lo = 1'b0;
        for (int e = 0; e < 32; e++) tick();
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL deb_seek_entry: got %b expected 10", state); end
        for (int j = 0; j < 8; j++) begin
            lim_hi = pat[j];
            tick();
            exp_end = (j == 7);
            n_checks++; if (cnt_l !== !exp_end) begin n_fail++; $display("FAIL deb_cnt_l j=%0d: got %b expected %b", j, cnt_l, !exp_end); end
            n_checks++; if (done !== exp_end) begin n_fail++; $display("FAIL deb_done j=%0d: got %b expected %b", j, done, exp_end); end
        end
        en = 1'b0; lim_hi = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL deb_to_idle: got %b expected 00", state); end
    endtask

    task automatic test_inactive_limit();
        logic exp_end;
        en = 1'b1; lim_hi = 1'b0; lim_lo = 1'b1;
        for (int e = 0; e < 60; e++) begin
            tick();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL inact_done e=%0d: got %b expected 0", e, done); end
        end
        n_checks++; if (cnt_l !== 1'b1 || state !== 2'b10 || dir !== 1'b0) begin n_fail++; $display("FAIL inact_seek: got cnt_l %b state %b dir %b expected 1/10/0", cnt_l, state, dir); end
        lim_hi = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_end = (j == 3);
            n_checks++; if (done !== exp_end || cnt_l !== !exp_end) begin n_fail++; $display("FAIL both_high j=%0d: got done %b cnt_l %b expected %b/%b", j, done, cnt_l, exp_end, !exp_end); end
        end
        en = 1'b0; lim_hi = 1'b0; lim_lo = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL inact_to_idle: got %b expected 00", state); end
    endtask

    task automatic test_en_drop();
        logic [1:0] exp_st;
        en = 1'b1; lim_hi = 1'b1; lim_lo = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL drop_in_guard: got %b expected 01", state); end
        en = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00 || cnt_l !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got state %b cnt_l %b expected 00/0", state, cnt_l); end
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL drop_idle_hold: got %b expected 00", state); end
        en = 1'b1;
        for (int e = 0; e < 35; e++) begin
            tick();
            exp_st = (e <= 30) ? 2'b01 : 2'b10;
            n_checks++; if (state !== exp_st || cnt_l !== 1'b1) begin n_fail++; $display("FAIL restart e=%0d: got state %b cnt_l %b expected %b/1", e, state, cnt_l, exp_st); end
        end
        tick();
        n_checks++; if (done !== 1'b1 || state !== 2'b11) begin n_fail++; $display("FAIL restart_fin: got done %b state %b expected 1/11", done, state); end
        en = 1'b0; lim_hi = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_seek();
        en = 1'b1; lim_hi = 1'b0; lim_lo = 1'b0;
        for (int e = 0; e < 34; e++) tick();
        n_checks++; if (state !== 2'b10 || cnt_l !== 1'b1) begin n_fail++; $display("FAIL mid_seek_pre: got state %b cnt_l %b expected 10/1", state, cnt_l); end
        #2 rst_n = 1'b0;
        lim_hi = 1'b1;
        #1;
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL async_state: got %b expected 00", state); end
        n_checks++; if (cnt_l !== 1'b0 || dir !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_outputs: got cnt_l %b dir %b done %b expected 0/0/0", cnt_l, dir, done); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (done !== 1'b0 || state !== 2'b00) begin n_fail++; $display("FAIL async_hold k=%0d: got done %b state %b expected 0/00", k, done, state); end
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_checks++; if (state !== 2'b01 || cnt_l !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL post_reset_start: got state %b cnt_l %b done %b expected 01/1/0", state, cnt_l, done); end
        en = 1'b0; lim_hi = 1'b0;
        tick();
    endtask

    task automatic test_bidir();
        logic exp_dir;
        b_en = 1'b1; b_lim_hi = 1'b1; b_lim_lo = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            exp_dir = (e >= 5);
            n_checks++; if (b_cnt_l !== 1'b1 || b_done !== 1'b0) begin n_fail++; $display("FAIL bidir_run e=%0d: got cnt_l %b done %b expected 1/0", e, b_cnt_l, b_done); end
            n_checks++; if (b_dir !== exp_dir) begin n_fail++; $display("FAIL bidir_dir e=%0d: got %b expected %b", e, b_dir, exp_dir); end
            if (e == 3) begin
                n_checks++; if (b_state !== 2'b10) begin n_fail++; $display("FAIL bidir_seek1: got %b expected 10", b_state); end
            end
            if (e == 5) begin
                n_checks++; if (b_state !== 2'b01) begin n_fail++; $display("FAIL bidir_reguard: got %b expected 01", b_state); end
                b_lim_hi = 1'b0; b_lim_lo = 1'b1;
            end
        end
        tick();
        n_checks++; if (b_cnt_l !== 1'b0 || b_done !== 1'b1 || b_state !== 2'b11 || b_dir !== 1'b1) begin n_fail++; $display("FAIL bidir_fin: got cnt_l %b done %b state %b dir %b expected 0/1/11/1", b_cnt_l, b_done, b_state, b_dir); end
        tick();
        n_checks++; if (b_done !== 1'b0 || b_dir !== 1'b1) begin n_fail++; $display("FAIL bidir_fin_hold: got done %b dir %b expected 0/1", b_done, b_dir); end
        b_en = 1'b0; b_lim_lo = 1'b0;
        tick();
        n_checks++; if (b_state !== 2'b00 || b_dir !== 1'b0) begin n_fail++; $display("FAIL bidir_idle: got state %b dir %b expected 00/0", b_state, b_dir); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_sweep();
        test_debounce();
        test_inactive_limit();
        test_en_drop();
        test_reset_mid_seek();
        test_bidir();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
